sumador_segmentado: RTL and testbench
=====================================

// Module: sumador_segmentado
// PURPOSE
//  - Parametrised, pipelined add/subtract unit. Next generation of the 4-bit
//    combinational ripple adder: WIDTH-bit operands, STAGES pipeline segments.
//  - Valid/ready handshake on input and output; full stall under back-pressure.
//  - Arithmetic datapath primitive for the practical designs; one op per cycle.
// PARAMETERS
//  - WIDTH   8  operand/result width in bits; WIDTH % STAGES == 0 (elaboration error otherwise)
//  - STAGES  2  pipeline segments = latency in cycles; SEG = WIDTH/STAGES bits per segment
// PORTS
//  - clk        in   1      single clock, rising edge
//  - rst_n      in   1      asynchronous, active-low reset
//  - in_valid   in   1      operands presented this cycle
//  - in_ready   out  1      unit accepts operands this cycle
//  - a          in   WIDTH  operand A
//  - b          in   WIDTH  operand B
//  - c_in       in   1      carry-in (add) / borrow-in (sub)
//  - sub        in   1      0: a+b+c_in ; 1: a-b-c_in
//  - out_valid  out  1      result valid
//  - out_ready  in   1      consumer takes result this cycle
//  - sum        out  WIDTH  result
//  - carry      out  1      carry-out; in sub mode 1 = no borrow
//  - ovf        out  1      signed overflow (only with SUMADOR_OVF_EN)
// BEHAVIOUR
//  - Arithmetic: bb = sub ? ~b : b; ci = sub ? ~c_in : c_in; {carry,sum} = a + bb + ci, modulo 2^WIDTH.
//  - Stage k (0..STAGES-1) adds segment k (bits k*SEG +: SEG) with carry from stage k-1, registered.
//  - Skew: segments >k of a/bb are delayed k stages; finished low segments are delayed to the output.
//  - adv = ~out_valid | out_ready; in_ready = adv (combinational); the whole pipeline moves only when adv=1.
//  - A transfer happens when in_valid & in_ready. Each stage carries a valid bit; bubbles propagate as valid=0.
//  - Latency: exactly STAGES advancing cycles from input transfer to out_valid=1. Throughput 1/cycle when out_ready=1.
//  - Stall (out_ready=0, out_valid=1): all stage registers, sum, carry and ovf hold; in_ready=0; no data lost or duplicated.
//  - Simultaneous out_ready & in_valid when full: output retires and new operand enters in the same cycle.
//  - Reset (incl. mid-operation): all valid bits, sum, carry and ovf -> 0 immediately; in-flight ops discarded; in_ready=1 after reset.
//  - Operand regs hold unknown data when valid=0; sum/carry/ovf update only on an advancing cycle.
//  - No FSM beyond the per-stage valid chain; STAGES=1 degenerates to a registered adder.
// CONFIGURATION
//  - Macro SUMADOR_OVF_EN defined: port ovf present; ovf = carry into MSB XOR carry out of MSB
//    (after b inversion), registered with the final stage; reset 0, held on stall.
//  - Undefined: no ovf port, no extra logic; all other behaviour identical.
// STRUCTURE
//  - Shared header sumador_defs.vh: localparams ADD=1'b0, SUB=1'b1; SEG derivation macro;
//    WIDTH%STAGES check.
//  - Sub-module sumador_seg: combinational SEG-bit adder slice (a, b, ci -> s, co, c_msb),
//    instantiated once per stage via generate.
//  - Top holds skew/de-skew registers, valid chain, handshake logic.
// TESTING  (WIDTH=8, STAGES=2, SUMADOR_OVF_EN defined)
//  - Reset: rst_n=0 -> out_valid=0, sum=0x00, carry=0, ovf=0, in_ready=1.
//  - a=0x00 b=0x00 c_in=1 sub=0 -> 2 cycles later out_valid=1, sum=0x01, carry=0.
//  - a=0xFF b=0x01 c_in=0 -> sum=0x00 carry=1; a=0x7F b=0x01 -> sum=0x80 ovf=1.
//  - Back-to-back, out_ready=1: {0xFF+0xFF+1, 0x00+0xFF+1, 0x55+0xAA+0} ->
//    consecutive cycles: 0xFF/c1, 0x00/c1, 0xFF/c0.
//  - Stall: pipeline full, out_ready=0 for 3 cycles -> in_ready=0, sum stable,
//    all results later delivered in order.
//  - Sub: a=0x05 b=0x07 c_in=0 sub=1 -> sum=0xFE carry=0; rst_n pulsed mid-flight -> out_valid=0, no stale output.

Source files
------------

// File: rtl/sumador_segmentado_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
// Holds the operation encoding and the segment-width/configuration helpers.
package sumador_segmentado_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    // Bits handled by each pipeline segment.
    function automatic int seg_width(input int width, input int stages);
        return width / stages;
    endfunction

    // A legal configuration splits the operand into equal segments.
    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (width >= stages) && (width % stages == 0);
    endfunction

endpackage

// File: rtl/sumador_segmentado_seg.sv
// sumador_seg: combinational SEG-bit adder slice, one per pipeline stage.
// Ports: a, b (SEG) operands, ci carry-in; s (SEG) sum, co carry-out.
module sumador_seg #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co
);

    logic [SEG:0] t;

    assign t  = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};
    assign s  = t[SEG-1:0];
    assign co = t[SEG];

endmodule

// File: rtl/sumador_segmentado.sv
// sumador_segmentado: pipelined WIDTH-bit add/subtract, STAGES segments,
// valid/ready handshake with full stall under back-pressure.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready, a, b, c_in, sub
// (0: a+b+c_in, 1: a-b-c_in); out_valid/out_ready, sum, carry
// (in sub mode 1 = no borrow); ovf signed overflow.
// Build option: define SUMADOR_OVF_EN to add the ovf port and its logic.
module sumador_segmentado
    import sumador_segmentado_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef SUMADOR_OVF_EN
    output logic             ovf,
`endif
    output logic             carry
);

    localparam int SEG  = seg_width(WIDTH, STAGES);
    localparam int LAST = STAGES - 1;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("sumador_segmentado: WIDTH must be a multiple of STAGES");
    end

    logic             adv;
    logic [WIDTH-1:0] bb;
    logic             ci;

    // Stage inputs: stage 0 sees the ports, stage k sees register k-1.
    logic [WIDTH-1:0] in_a [STAGES];
    logic [WIDTH-1:0] in_b [STAGES];
    logic [WIDTH-1:0] in_s [STAGES];
    logic             in_c [STAGES];
    logic             in_v [STAGES];

    logic [SEG-1:0]   sg_s  [STAGES];
    logic             sg_co [STAGES];

    // Registers after each stage; a/b keep the not-yet-added upper
    // segments, s accumulates the finished lower segments.
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic             c_q [STAGES];
    logic             c_d [STAGES];
    logic             v_q [STAGES];
    logic             v_d [STAGES];

    // The whole pipeline moves in lock-step, only when the output
    // slot is empty or being drained.
    assign adv      = ~v_q[LAST] | out_ready;
    assign in_ready = adv;

    // Subtraction as a + ~b + ~borrow.
    assign bb = (sub == SUB) ? ~b : b;
    assign ci = (sub == SUB) ? ~c_in : c_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign in_a[k] = a;
            assign in_b[k] = bb;
            assign in_s[k] = '0;
            assign in_c[k] = ci;
            assign in_v[k] = in_valid;
        end else begin : g_next
            assign in_a[k] = a_q[k-1];
            assign in_b[k] = b_q[k-1];
            assign in_s[k] = s_q[k-1];
            assign in_c[k] = c_q[k-1];
            assign in_v[k] = v_q[k-1];
        end

        sumador_seg #(
            .SEG (SEG)
        ) u_seg (
            .a  (in_a[k][k*SEG +: SEG]),
            .b  (in_b[k][k*SEG +: SEG]),
            .ci (in_c[k]),
            .s  (sg_s[k]),
            .co (sg_co[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            v_d[k] = v_q[k];
            a_d[k] = a_q[k];
            b_d[k] = b_q[k];
            s_d[k] = s_q[k];
            c_d[k] = c_q[k];
            if (adv) begin
                v_d[k] = in_v[k];
                a_d[k] = in_a[k];
                b_d[k] = in_b[k];
                s_d[k] = in_s[k];
                s_d[k][k*SEG +: SEG] = sg_s[k];
                c_d[k] = sg_co[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_d[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
            end
        end
    end

    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign carry     = c_q[LAST];

`ifdef SUMADOR_OVF_EN
    logic ovf_q;
    logic ovf_d;

    // Carry into the MSB is a^b^s at the MSB; overflow when it differs
    // from the carry out of the MSB.
    always_comb begin
        ovf_d = ovf_q;
        if (adv) begin
            ovf_d = in_a[LAST][WIDTH-1] ^ in_b[LAST][WIDTH-1]
                  ^ sg_s[LAST][SEG-1] ^ sg_co[LAST];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_sumador_segmentado.sv
// Self-checking bench for sumador_segmentado (WIDTH=8, STAGES=2).
// Directed cases plus random traffic against a slot-based reference model.
module tb_sumador_segmentado;

    localparam int W = 8;
    localparam int S = 2;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry;
`ifdef SUMADOR_OVF_EN
    logic         ovf;
`endif

    int errors = 0;
    int checks = 0;
    int pops   = 0;

    // Model: one slot per pipeline stage, each holding {ovf, carry, sum}.
    logic         mv [S];
    logic [W+1:0] mr [S];

    sumador_segmentado #(
        .WIDTH  (W),
        .STAGES (S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef SUMADOR_OVF_EN
        .ovf       (ovf),
`endif
        .carry     (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W+1:0] ref_op(input logic [W-1:0] x,
                                            input logic [W-1:0] y,
                                            input logic ci,
                                            input logic s);
        logic [W-1:0] yy;
        logic         cc;
        logic [W:0]   t;
        logic         v;
        yy = s ? ~y : y;
        cc = s ? ~ci : ci;
        t  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
        v  = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
        return {v, t};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mdl_clear();
        for (int k = 0; k < S; k++) begin
            mv[k] = 1'b0;
            mr[k] = '0;
        end
    endtask

    // Check at the falling edge, update the model, then step past the
    // next rising edge so new inputs can be driven.
    task automatic cyc();
        logic adv;
        @(negedge clk);
        chk("out_valid", {31'b0, out_valid}, {31'b0, mv[S-1]});
        chk("in_ready", {31'b0, in_ready},
            {31'b0, ~mv[S-1] | out_ready});
        if (mv[S-1]) begin
            chk("sum", {24'b0, sum}, {24'b0, mr[S-1][W-1:0]});
            chk("carry", {31'b0, carry}, {31'b0, mr[S-1][W]});
`ifdef SUMADOR_OVF_EN
            chk("ovf", {31'b0, ovf}, {31'b0, mr[S-1][W+1]});
`endif
            if (out_ready) pops++;
        end
        adv = ~mv[S-1] | out_ready;
        if (rst_n && adv) begin
            for (int k = S - 1; k > 0; k--) begin
                mv[k] = mv[k-1];
                mr[k] = mr[k-1];
            end
            mv[0] = in_valid;
            mr[0] = ref_op(a, b, c_in, sub);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic s);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        c_in     = ci;
        sub      = s;
        cyc();
        in_valid = 1'b0;
    endtask

    initial begin
        int p0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        c_in      = 1'b0;
        sub       = 1'b0;
        mdl_clear();
        repeat (3) @(posedge clk);
        #1;

        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_sum", {24'b0, sum}, 32'd0);
        chk("rst_carry", {31'b0, carry}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef SUMADOR_OVF_EN
        chk("rst_ovf", {31'b0, ovf}, 32'd0);
`endif
        rst_n     = 1'b1;
        out_ready = 1'b1;
        cyc();

        // Latency: exactly two advancing cycles.
        send(8'h00, 8'h00, 1'b1, 1'b0);
        chk("lat_1", {31'b0, out_valid}, 32'd0);
        cyc();
        chk("lat_2", {31'b0, out_valid}, 32'd1);
        chk("lat_sum", {24'b0, sum}, 32'h01);
        cyc();

        send(8'hFF, 8'h01, 1'b0, 1'b0);
        send(8'h7F, 8'h01, 1'b0, 1'b0);
        repeat (3) cyc();

        // Back-to-back: three results on consecutive cycles.
        p0 = pops;
        send(8'hFF, 8'hFF, 1'b1, 1'b0);
        send(8'h00, 8'hFF, 1'b1, 1'b0);
        send(8'h55, 8'hAA, 1'b0, 1'b0);
        cyc();
        cyc();
        chk("b2b_count", pops - p0, 32'd3);
        cyc();

        // Stall with a full pipeline, then drain in order.
        send(8'h10, 8'h20, 1'b0, 1'b0);
        send(8'h30, 8'h40, 1'b1, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 8'h81;
        b         = 8'h82;
        c_in      = 1'b0;
        sub       = 1'b0;
        repeat (3) begin
            cyc();
            chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        repeat (3) cyc();

        // Subtraction with borrow.
        send(8'h05, 8'h07, 1'b0, 1'b1);
        cyc();
        chk("sub_sum", {24'b0, sum}, 32'hFE);
        chk("sub_carry", {31'b0, carry}, 32'd0);
        cyc();

        // Reset pulsed with an operation in flight.
        send(8'h12, 8'h34, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_sum", {24'b0, sum}, 32'd0);
        mdl_clear();
        cyc();
        rst_n = 1'b1;
        repeat (3) cyc();

        // Random traffic with random back-pressure.
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            a         = W'($urandom);
            b         = W'($urandom);
            c_in      = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
